// File: rtl/dotp_pkg.sv
// rtl/dotp_pkg.sv - shared types and widths for the dot-product sequencer
//
// Contents:
//   OP_W    operand width fed to the 4-bit sequential multiplier
//   PROD_W  product width returned by the multiplier
//   state_t sequencer FSM states (2-bit)
//   pair_t  buffered operand pair {a, b}
package dotp_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } pair_t;

endpackage

// File: rtl/dotp_operand_fifo.sv
// rtl/dotp_operand_fifo.sv - single-clock FIFO of multiplier operand pairs
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst    asynchronous active-low reset (empties the FIFO)
//   i_push   write request; ignored while o_full
//   i_data   operand pair to write
//   i_pop    read request; ignored while o_empty
//   o_data   head-of-FIFO operand pair (valid while !o_empty)
//   o_full   FIFO holds DEPTH entries
//   o_empty  FIFO holds no entries
//
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// Full/empty come from the registered occupancy count only, so a pop in the
// same cycle never lets a push into a full FIFO.
module dotp_operand_fifo
    import dotp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_push,
    input  pair_t i_data,
    input  logic  i_pop,
    output pair_t o_data,
    output logic  o_full,
    output logic  o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    pair_t            r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - feeds a sequential multiplier and sums N_TERMS products
//
// Optional build macro: DOTP_SATURATE_EN
//   defined   - accumulator clamps at 2^ACC_W-1 until the result is consumed
//   undefined - accumulator wraps modulo 2^ACC_W
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-low reset
//   i_in_valid   operand pair valid
//   o_in_ready   FIFO can accept a pair
//   i_in_a       multiplicand
//   i_in_b       multiplier operand
//   o_mul_ena    one-cycle start pulse to the multiplier
//   o_mul_a      operand A to the multiplier, held until mul_done
//   o_mul_b      operand B to the multiplier, held until mul_done
//   i_mul_y      product from the multiplier
//   i_mul_done   product-valid pulse from the multiplier
//   o_sum        dot-product result (the accumulator)
//   o_sum_valid  result valid
//   i_sum_ready  consumer accepts the result
//   o_busy       low only in S_IDLE with no partial sum in progress
//   o_state      current FSM state (debug)
module dot_product_sequencer
    import dotp_pkg::*;
#(
    parameter int N_TERMS    = 4,
    parameter int ACC_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [OP_W-1:0]   i_in_a,
    input  logic [OP_W-1:0]   i_in_b,
    output logic              o_mul_ena,
    output logic [OP_W-1:0]   o_mul_a,
    output logic [OP_W-1:0]   o_mul_b,
    input  logic [PROD_W-1:0] i_mul_y,
    input  logic              i_mul_done,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_sum_valid,
    input  logic              i_sum_ready,
    output logic              o_busy,
    output logic [1:0]        o_state
);

    localparam int TERM_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [TERM_W-1:0] LAST_TERM = TERM_W'(N_TERMS - 1);

    state_t              r_state;
    logic                r_mul_ena;
    logic [OP_W-1:0]     r_mul_a;
    logic [OP_W-1:0]     r_mul_b;
    logic [ACC_W-1:0]    r_acc;
    logic [TERM_W-1:0]   r_term_cnt;
    logic                r_sum_valid;

    pair_t               w_in_pair;
    pair_t               w_head;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_push;
    logic                w_pop;
    logic [ACC_W-1:0]    w_acc_next;

    assign w_in_pair.a = i_in_a;
    assign w_in_pair.b = i_in_b;
    assign w_push      = i_in_valid && !w_fifo_full;
    // The head is consumed only when the FSM is ready to start a new term.
    assign w_pop       = (r_state == S_IDLE) && !w_fifo_empty;

    dotp_operand_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_in_pair),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef DOTP_SATURATE_EN
    // One extra bit catches the carry; once at the ceiling any further
    // non-negative product carries out again, so the clamp is sticky.
    logic [ACC_W:0] w_acc_wide;
    assign w_acc_wide = {1'b0, r_acc} + (ACC_W + 1)'(i_mul_y);
    assign w_acc_next = w_acc_wide[ACC_W] ? {ACC_W{1'b1}} : w_acc_wide[ACC_W-1:0];
`else
    assign w_acc_next = r_acc + ACC_W'(i_mul_y);
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_mul_ena   <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_acc       <= '0;
            r_term_cnt  <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_mul_a   <= w_head.a;
                        r_mul_b   <= w_head.b;
                        r_mul_ena <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mul_ena <= 1'b0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    // mul_done is only honoured here; pulses in other states are dropped.
                    if (i_mul_done) begin
                        r_acc <= w_acc_next;
                        if (r_term_cnt == LAST_TERM) begin
                            r_sum_valid <= 1'b1;
                            r_state     <= S_OUT;
                        end else begin
                            r_term_cnt <= r_term_cnt + TERM_W'(1);
                            r_state    <= S_IDLE;
                        end
                    end
                end
                S_OUT: begin
                    if (i_sum_ready) begin
                        r_acc       <= '0;
                        r_term_cnt  <= '0;
                        r_sum_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = !w_fifo_full;
    assign o_mul_ena   = r_mul_ena;
    assign o_mul_a     = r_mul_a;
    assign o_mul_b     = r_mul_b;
    assign o_sum       = r_acc;
    assign o_sum_valid = r_sum_valid;
    assign o_busy      = !((r_state == S_IDLE) && (r_term_cnt == '0));
    assign o_state     = r_state;

endmodule
